// File: rtl/i2c_target.sv
// I2C target engine: oversampled, glitch-filtered SCL/SDA, START/STOP detect,
// 7-bit address match, ACKed write delivery and byte-at-a-time read serving.
module i2c_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'h75,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       sel_o
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic       scl_p_q, sda_p_q;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d, first_q, first_d, ack_on_q, ack_on_d;
  logic       sda_oe_q, sda_oe_d, sel_q, sel_d;
  logic       rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
  logic       start_q, start_d, stop_q, stop_d;
  logic       tx_req;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // A level is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_cnt_d  = '0;
    sda_cnt_d  = '0;
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    if (scl_sync_q[1] != scl_f_q) begin
      if (scl_cnt_q == CNT_MAX) scl_f_d = scl_sync_q[1];
      else                      scl_cnt_d = scl_cnt_q + 4'd1;
    end
    if (sda_sync_q[1] != sda_f_q) begin
      if (sda_cnt_q == CNT_MAX) sda_f_d = sda_sync_q[1];
      else                      sda_cnt_d = sda_cnt_q + 4'd1;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign rx_byte   = {shift_q[6:0], sda_f_q};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    first_d    = first_q;
    ack_on_d   = ack_on_q;
    sda_oe_d   = sda_oe_q;
    sel_d      = sel_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    tx_req     = 1'b0;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      first_d   = 1'b1;
      ack_on_d  = 1'b0;
      sda_oe_d  = 1'b0;
      sel_d     = 1'b0;
      start_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = IDLE;
      ack_on_d = 1'b0;
      sda_oe_d = 1'b0;
      sel_d    = 1'b0;
      stop_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: sda_oe_d = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              ack_on_d  = 1'b0;
              // Address 0 (general call) is deliberately never matched.
              if (rx_byte[7:1] == DEVICE_ADDR && rx_byte[7:1] != 7'd0) begin
                rw_d    = rx_byte[0];
                state_d = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
              if (state_q == ADDR_ACK) sel_d = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                tx_req     = 1'b1;
                sda_oe_d   = ~tx_data_i[7];
                tx_shift_d = {tx_data_i[6:0], 1'b0};
                bit_cnt_d  = 4'd1;
                state_d    = TX_BYTE;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = RX_BYTE;
              end
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              bit_cnt_d  = '0;
              ack_on_d   = 1'b0;
              state_d    = RX_ACK;
            end
          end
        end
        TX_BYTE: begin
          // bit_cnt counts bits already presented; MSB went out at load time.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              state_d  = TX_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f_q) begin
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WAIT_STOP;
            end
          end else if (scl_fall && ack_on_q) begin
            tx_req     = 1'b1;
            sda_oe_d   = ~tx_data_i[7];
            tx_shift_d = {tx_data_i[6:0], 1'b0};
            bit_cnt_d  = 4'd1;
            ack_on_d   = 1'b0;
            state_d    = TX_BYTE;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      ack_on_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      sel_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      ack_on_q   <= ack_on_d;
      sda_oe_q   <= sda_oe_d;
      sel_q      <= sel_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_first_o = rx_first_q;
  assign tx_req_o   = tx_req & ~srst_i;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign sel_o      = sel_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench: a bus-level I2C master drives the target; write data and read data are
// checked against byte lists held by the bench.
module tb_i2c_target;
  localparam int H = 20;  // SCL half period in system clocks

  logic       clk = 1'b0;
  logic       srst_i = 1'b1;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic       glitch_en = 1'b0;
  logic       sda;
  logic [7:0] tx_data_i;
  logic       sda_oe_o, rx_valid_o, rx_first_o, tx_req_o, start_o, stop_o, sel_o;
  logic [7:0] rx_data_o;

  assign sda = ~(m_oe | sda_oe_o);

  i2c_target dut (
    .clk_i(clk), .srst_i(srst_i), .scl_i(scl), .sda_i(sda), .sda_oe_o(sda_oe_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_first_o(rx_first_o),
    .tx_req_o(tx_req_o), .tx_data_i(tx_data_i), .start_o(start_o), .stop_o(stop_o),
    .sel_o(sel_o)
  );

  always #20 clk = ~clk;

  int         n_checks = 0, n_fail = 0;
  logic [7:0] tx_vals [16];
  logic [7:0] wr_buf [8];
  logic [8:0] rx_log [256];
  int         tx_pos = 0, tx_req_cnt = 0, rx_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int         oe_viol = 0, oe_on_cnt = 0;
  logic       tx_pend = 1'b0, oe_prev = 1'b0;

  assign tx_data_i = tx_vals[tx_pos[3:0]];

  always @(negedge clk) begin
    if (tx_pend) tx_pos++;
    tx_pend = tx_req_o;
    if (tx_req_o) tx_req_cnt++;
    if (rx_valid_o) begin
      rx_log[rx_cnt[7:0]] = {rx_first_o, rx_data_o};
      rx_cnt++;
    end
    if (start_o) start_cnt++;
    if (stop_o) stop_cnt++;
    if (sda_oe_o) oe_on_cnt++;
    if (sda_oe_o !== oe_prev && scl === 1'b1) oe_viol++;
    oe_prev = sda_oe_o;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_bit(input logic b, output logic r);
    clks(H/2); m_oe = ~b;
    clks(H/2); scl = 1'b1;
    clks(H/2); r = sda;
    if (glitch_en) begin
      scl = 1'b0; clks(2); scl = 1'b1; clks(H/2 - 2);
    end else begin
      clks(H/2);
    end
    scl = 1'b0;
  endtask

  task automatic m_start();
    m_oe = 1'b0; clks(H/2);
    scl = 1'b1; clks(H);
    m_oe = 1'b1; clks(H);
    scl = 1'b0;
  endtask

  task automatic m_stop();
    clks(H/2); m_oe = 1'b1;
    clks(H/2); scl = 1'b1;
    clks(H);   m_oe = 1'b0;
    clks(H);
  endtask

  task automatic m_wr(input logic [7:0] b, output int ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, r);
    ack = (r == 1'b0) ? 1 : 0;
  endtask

  task automatic m_rd(output logic [7:0] d, input logic give_ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(~give_ack, r);
  endtask

  task automatic do_write(input int n, output int acks);
    int a;
    acks = 0;
    m_start();
    m_wr(8'hEA, a); acks += a;
    for (int i = 0; i < n; i++) begin m_wr(wr_buf[i], a); acks += a; end
    m_stop();
  endtask

  task automatic test_reset();
    srst_i = 1'b1; clks(3); srst_i = 1'b0; clks(1);
    n_checks++;
    if ({sda_oe_o, rx_data_o, rx_valid_o, rx_first_o, tx_req_o, start_o, stop_o, sel_o} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got oe=%b rx=%h v=%b f=%b req=%b st=%b sp=%b sel=%b, want all 0",
               sda_oe_o, rx_data_o, rx_valid_o, rx_first_o, tx_req_o, start_o, stop_o, sel_o);
    end
  endtask

  task automatic test_write();
    logic [7:0] v [4];
    int a, acks, base, s0, p0;
    v[0] = 8'h33; v[1] = 8'h33; v[2] = 8'hAA; v[3] = 8'hAA;
    base = rx_cnt; s0 = start_cnt; p0 = stop_cnt; acks = 0;
    m_start();
    m_wr(8'hEA, a); acks += a;
    n_checks++;
    if (sel_o !== 1'b1) begin n_fail++; $display("FAIL write_sel_after_addr: got %b want 1", sel_o); end
    for (int i = 0; i < 4; i++) begin m_wr(v[i], a); acks += a; end
    n_checks++;
    if (sel_o !== 1'b1) begin n_fail++; $display("FAIL write_sel_before_stop: got %b want 1", sel_o); end
    m_stop();
    n_checks++;
    if (acks != 5) begin n_fail++; $display("FAIL write_acks: got %0d want 5", acks); end
    n_checks++;
    if (rx_cnt - base != 4) begin n_fail++; $display("FAIL write_rx_count: got %0d want 4", rx_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_log[(base + i) % 256] !== {(i == 0), v[i]}) begin
        n_fail++;
        $display("FAIL write_rx_byte%0d: got first/data %h want %h", i, rx_log[(base + i) % 256], {(i == 0), v[i]});
      end
    end
    n_checks++;
    if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
      n_fail++; $display("FAIL write_start_stop: got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0);
    end
    n_checks++;
    if (sel_o !== 1'b0) begin n_fail++; $display("FAIL write_sel_after_stop: got %b want 0", sel_o); end
  endtask

  task automatic test_read_restart();
    logic [7:0] d0, d1;
    int a, acks, base, s0, r0, p;
    p = tx_pos;
    tx_vals[p % 16] = 8'h5A; tx_vals[(p + 1) % 16] = 8'hC3;
    base = rx_cnt; s0 = start_cnt; r0 = tx_req_cnt; acks = 0;
    m_start();
    m_wr(8'hEA, a); acks += a;
    m_wr(8'h33, a); acks += a;
    m_start();
    m_wr(8'hEB, a); acks += a;
    m_rd(d0, 1'b1);
    m_rd(d1, 1'b0);
    clks(H/2);
    n_checks++;
    if (sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nack: got %b want 0", sda_oe_o); end
    m_stop();
    n_checks++;
    if (acks != 3) begin n_fail++; $display("FAIL read_acks: got %0d want 3", acks); end
    n_checks++;
    if (d0 !== 8'h5A || d1 !== 8'hC3) begin n_fail++; $display("FAIL read_data: got %h %h want 5a c3", d0, d1); end
    n_checks++;
    if (tx_req_cnt - r0 != 2) begin n_fail++; $display("FAIL read_tx_req: got %0d want 2", tx_req_cnt - r0); end
    n_checks++;
    if (start_cnt - s0 != 2) begin n_fail++; $display("FAIL read_starts: got %0d want 2", start_cnt - s0); end
    n_checks++;
    if (rx_cnt - base != 1 || rx_log[base % 256] !== 9'h133) begin
      n_fail++; $display("FAIL read_reg_addr: got count %0d entry %h want 1 133", rx_cnt - base, rx_log[base % 256]);
    end
  endtask

  task automatic test_mismatch();
    int a, acks, base, on0;
    base = rx_cnt; on0 = oe_on_cnt; acks = 0;
    m_start();
    m_wr(8'h14, a); acks += a;
    m_wr(8'h33, a); acks += a;
    n_checks++;
    if (sel_o !== 1'b0) begin n_fail++; $display("FAIL mismatch_sel: got %b want 0", sel_o); end
    m_stop();
    n_checks++;
    if (acks != 0 || oe_on_cnt != on0) begin
      n_fail++; $display("FAIL mismatch_no_drive: got acks %0d oe_cycles %0d want 0 0", acks, oe_on_cnt - on0);
    end
    n_checks++;
    if (rx_cnt != base) begin n_fail++; $display("FAIL mismatch_no_rx: got %0d want 0", rx_cnt - base); end
  endtask

  task automatic test_partial_stop();
    logic r;
    int a, acks, base, n;
    base = rx_cnt;
    m_start();
    m_wr(8'hEA, a);
    for (int i = 0; i < 4; i++) m_bit(1'($urandom), r);
    m_stop();
    n_checks++;
    if (rx_cnt != base || sda_oe_o !== 1'b0 || sel_o !== 1'b0) begin
      n_fail++; $display("FAIL partial_abort: got rx %0d oe %b sel %b want 0 0 0", rx_cnt - base, sda_oe_o, sel_o);
    end
    n = 2;
    for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
    do_write(n, acks);
    n_checks++;
    if (acks != n + 1 || rx_cnt - base != n || rx_log[base % 256] !== {1'b1, wr_buf[0]}
        || rx_log[(base + 1) % 256] !== {1'b0, wr_buf[1]}) begin
      n_fail++; $display("FAIL partial_next_write: got acks %0d count %0d first %h want %0d %0d %h",
                         acks, rx_cnt - base, rx_log[base % 256], n + 1, n, {1'b1, wr_buf[0]});
    end
  endtask

  task automatic test_glitch();
    int acks, base, s0, p0;
    base = rx_cnt; s0 = start_cnt; p0 = stop_cnt;
    wr_buf[0] = 8'($urandom);
    glitch_en = 1'b1;
    do_write(1, acks);
    glitch_en = 1'b0;
    n_checks++;
    if (acks != 2 || rx_cnt - base != 1 || rx_log[base % 256] !== {1'b1, wr_buf[0]}) begin
      n_fail++; $display("FAIL glitch_data: got acks %0d count %0d entry %h want 2 1 %h",
                         acks, rx_cnt - base, rx_log[base % 256], {1'b1, wr_buf[0]});
    end
    n_checks++;
    if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
      n_fail++; $display("FAIL glitch_start_stop: got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0);
    end
  endtask

  task automatic test_reset_mid_ack();
    logic r;
    int acks, base;
    logic [7:0] adr;
    adr = 8'hEA;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(adr[i], r);
    m_oe = 1'b0;
    clks(12);
    n_checks++;
    if (sda_oe_o !== 1'b1) begin n_fail++; $display("FAIL rst_ack_driven: got %b want 1", sda_oe_o); end
    srst_i = 1'b1; clks(1);
    n_checks++;
    if ({sda_oe_o, rx_data_o, rx_valid_o, rx_first_o, tx_req_o, start_o, stop_o, sel_o} !== 15'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got oe=%b rx=%h sel=%b want all 0", sda_oe_o, rx_data_o, sel_o);
    end
    srst_i = 1'b0;
    m_stop();
    base = rx_cnt;
    for (int i = 0; i < 3; i++) wr_buf[i] = 8'($urandom);
    do_write(3, acks);
    n_checks++;
    if (acks != 4 || rx_cnt - base != 3) begin
      n_fail++; $display("FAIL rst_next_write: got acks %0d count %0d want 4 3", acks, rx_cnt - base);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rx_log[(base + i) % 256] !== {(i == 0), wr_buf[i]}) begin
        n_fail++; $display("FAIL rst_next_byte%0d: got %h want %h", i, rx_log[(base + i) % 256], {(i == 0), wr_buf[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks, base, n, r0, p, a;
    logic [7:0] d;
    for (int it = 0; it < 3; it++) begin
      n = 1 + int'($urandom_range(2));
      for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
      base = rx_cnt;
      do_write(n, acks);
      n_checks++;
      if (acks != n + 1 || rx_cnt - base != n) begin
        n_fail++; $display("FAIL b2b_write%0d: got acks %0d count %0d want %0d %0d", it, acks, rx_cnt - base, n + 1, n);
      end
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (rx_log[(base + i) % 256] !== {(i == 0), wr_buf[i]}) begin
          n_fail++; $display("FAIL b2b_wbyte%0d_%0d: got %h want %h", it, i, rx_log[(base + i) % 256], {(i == 0), wr_buf[i]});
        end
      end
      n = 1 + int'($urandom_range(2));
      p = tx_pos; r0 = tx_req_cnt;
      for (int i = 0; i < n; i++) tx_vals[(p + i) % 16] = 8'($urandom);
      m_start();
      m_wr(8'hEB, a);
      for (int i = 0; i < n; i++) begin
        m_rd(d, (i != n - 1));
        n_checks++;
        if (d !== tx_vals[(p + i) % 16]) begin
          n_fail++; $display("FAIL b2b_rbyte%0d_%0d: got %h want %h", it, i, d, tx_vals[(p + i) % 16]);
        end
      end
      m_stop();
      n_checks++;
      if (a != 1 || tx_req_cnt - r0 != n) begin
        n_fail++; $display("FAIL b2b_read%0d: got ack %0d reqs %0d want 1 %0d", it, a, tx_req_cnt - r0, n);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tx_vals[i] = 8'h00;
    test_reset();
    test_write();
    test_read_restart();
    test_mismatch();
    test_partial_stop();
    test_glitch();
    test_reset_mid_ack();
    test_back_to_back();
    n_checks++;
    if (oe_viol != 0) begin n_fail++; $display("FAIL oe_change_while_scl_high: got %0d want 0", oe_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) engine for the on-board I2C bus, the responder counterpart of the bit-level I2C master engine. Oversamples SCL/SDA on the system clock, detects START/repeated START/STOP, matches a 7-bit device address, ACKs and delivers written bytes, and serves read bytes from the user side. It lets the master path be looped back in simulation and lets the FPGA act as a bus peripheral.

## Interface
- DEVICE_ADDR, 7'h75, 7-bit address this target answers to.
- FILTER_LEN, 4, number of consecutive identical samples required before a synchronized SCL/SDA level is accepted (glitch filter, 1..15).

- clk_i  in  1  system clock.
- srst_i  in  1  reset; one clock, synchronous, active-high.
- scl_i  in  1  bus SCL (asynchronous).
- sda_i  in  1  bus SDA input (asynchronous).
- sda_oe_o  out  1  1 = pull SDA low (open-drain); 0 = release. Never drives high.
- rx_data_o  out  8  last byte written by master, MSB first on the wire.
- rx_valid_o  out  1  one-cycle pulse, rx_data_o valid.
- rx_first_o  out  1  qualifies rx_valid_o: first data byte after an address-write phase (register address).
- tx_req_o  out  1  one-cycle pulse requesting the next read byte.
- tx_data_i  in  8  read byte; sampled in the cycle tx_req_o = 1.
- start_o  out  1  one-cycle pulse on any START/repeated START.
- stop_o  out  1  one-cycle pulse on STOP.
- sel_o  out  1  high while this target is addressed (from address ACK until STOP/START).

## Operation
- Input path: 2-FF synchronizer per line, then FILTER_LEN stability filter; filtered levels scl_f/sda_f reset to 1. Edge flags derived from scl_f/sda_f registered copies.
- START: sda_f falls while scl_f = 1. STOP: sda_f rises while scl_f = 1. Both override every state.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- IDLE --START--> ADDR (bit counter = 0, rx_first armed).
- ADDR: shift sda_f on each scl_f rising edge; after 8th bit: address match -> ADDR_ACK, else -> WAIT_STOP.
- ADDR_ACK: on the scl_f falling edge ending bit 8, sda_oe_o = 1; released on the falling edge after the 9th clock. R/W = 0 -> RX_BYTE; R/W = 1 -> tx_req_o pulse at the ACK-release falling edge, load tx_data_i, -> TX_BYTE.
- RX_BYTE: 8 rising-edge samples; after 8th: rx_data_o updated, rx_valid_o pulse (rx_first_o = 1 only for first byte since address), -> RX_ACK (always ACK, same drive timing as ADDR_ACK), then RX_BYTE.
- TX_BYTE: on each scl_f falling edge present next bit (MSB first): sda_oe_o = ~bit. After 8th bit release on falling edge -> TX_ACK.
- TX_ACK: sample sda_f at 9th rising edge. 0 (ACK) -> tx_req_o pulse at next falling edge, load, -> TX_BYTE. 1 (NACK) -> WAIT_STOP, SDA released.
- WAIT_STOP: sda_oe_o = 0; leaves only on START (-> ADDR) or STOP (-> IDLE).
- START in any state: release SDA, start_o pulse, sel_o = 0, -> ADDR. STOP in any state: release SDA, stop_o pulse, sel_o = 0, -> IDLE. No partial byte is reported.
- General call (address 0) not supported: treated as mismatch.

## Timing
- Reset values: sda_oe_o 0, rx_data_o 0, rx_valid_o 0, rx_first_o 0, tx_req_o 0, start_o 0, stop_o 0, sel_o 0; state IDLE; filters 1.
- Reset mid-transfer: SDA released in the cycle after srst_i; bus state lost; target ignores traffic until next START.
- Input latency: bus edge to filtered edge = 2 + FILTER_LEN clocks (6 at defaults); this delay is the SDA hold after SCL fall.
- rx_valid_o asserts 1 clock after the filtered 8th rising edge.
- sda_oe_o changes exactly 1 clock after the filtered SCL falling edge; never changes while scl_f = 1.
- tx_req_o and byte load are same-cycle; tx_data_i needs no hold afterwards.
- Requirement: SCL high/low phases > 2*(2+FILTER_LEN) clocks (25 MHz / 100 kHz gives 125 per phase).

## Test plan
- Write: START, 0xEA, 0x33, 0x33, 0xAA, 0xAA, STOP (25 MHz, 100 kHz SCL) -> SDA low on all five 9th clocks; rx_valid_o 4 pulses with 0x33, 0x33, 0xAA, 0xAA; rx_first_o only on first; sel_o high through; stop_o once.
- Read with restart: START, 0xEA, 0x33, Sr, 0xEB, master ACK, NACK, STOP; tx_data_i = 0x5A then 0xC3 -> master reads 0x5A, 0xC3; tx_req_o exactly 2 pulses; SDA released after NACK; start_o 2 pulses.
- Address mismatch: START, 0x14, 0x33, STOP -> sda_oe_o stays 0, no rx_valid_o, sel_o 0.
- STOP after 4 bits of a data byte -> no rx_valid_o, state IDLE, SDA released; following write to 0xEA ACKed normally.
- 2-clock glitch low on SCL while SCL high, FILTER_LEN = 4 -> no bit shifted, no START/STOP detected.
- srst_i asserted while target drives ACK -> sda_oe_o 0 next cycle; all outputs at reset values; next full write transaction succeeds.
